// File: rtl/gpr_arb_pkg.sv
// gpr_arb_pkg
//   Shared constants for the register-file write arbiter: register and data
//   widths, the hard-wired zero register, the default flag register index and
//   the FSM state encoding.
package gpr_arb_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_AW-1:0] REG_ZERO         = 5'd0;
    localparam logic [REG_AW-1:0] FLAG_REG_DEFAULT = 5'd30;

    // FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FLAG = 1'b1;

endpackage

// File: rtl/gpr_write_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin winner selection.
//   Ports:
//     valid [NREQ-1:0]  request vector
//     ptr   [PTR_W-1:0] index of the last winner; search starts at ptr+1
//     grant [NREQ-1:0]  one-hot winner (all zero when nothing is valid)
//     idx   [PTR_W-1:0] index of the winner (0 when nothing is valid)
//     any               at least one request is valid
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0] cand;

    // Walk the ring once, starting just after ptr; the first valid hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == LAST) ? '0 : cand + PTR_W'(1);
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/gpr_write_arbiter.sv
// gpr_write_arbiter
//   Shares the single register-file write port between NREQ writeback
//   sources using round-robin arbitration. A request that also updates the
//   overflow flag costs a second write cycle to FLAG_REG, so the register
//   file only ever sees one write per cycle.
//   Ports:
//     clk, rst        clock (rising edge) and synchronous active-high reset
//     req_valid/ready per-requester handshake; a transfer happens when both
//                     are high at a rising edge
//     req_reg         destination register, requester i at [5i+4:5i]
//     req_data        write data, requester i at [32i+31:32i]
//     req_flag_we     request also writes the overflow flag to FLAG_REG
//     req_ovf         overflow value for that flag write
//     gpr_rw/wreg/wdata registered register-file write port
//     busy            high while the flag write cycle is in progress
//     state_dbg       current FSM state (ST_IDLE / ST_FLAG)
//
//   Handshake: req_ready is combinational, one-hot at the round-robin winner
//   among valid requesters, and only ever asserted in IDLE outside reset.
//   A requester keeps valid and its payload stable until it sees ready.
module gpr_write_arbiter
    import gpr_arb_pkg::*;
#(
    parameter int                NREQ     = 2,
    parameter logic [REG_AW-1:0] FLAG_REG = FLAG_REG_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [REG_AW*NREQ-1:0]   req_reg,
    input  logic [DATA_W*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]          req_flag_we,
    input  logic [NREQ-1:0]          req_ovf,
    output logic                     gpr_rw,
    output logic [REG_AW-1:0]        gpr_wreg,
    output logic [DATA_W-1:0]        gpr_wdata,
    output logic                     busy,
    output logic [0:0]               state_dbg
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [0:0]        state;
    logic [PTR_W-1:0]  rr_ptr;
    logic              ovf_q;

    logic [NREQ-1:0]   grant;
    logic [PTR_W-1:0]  win_idx;
    logic              win_any;

    logic [REG_AW-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic              sel_flag_we;
    logic              sel_ovf;
    logic              accept;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // A grant only exists over valid requesters, so ready implies a transfer.
    assign accept    = win_any && (state == ST_IDLE) && !rst;
    assign req_ready = accept ? grant : '0;
    assign busy      = (state == ST_FLAG);
    assign state_dbg = state;

    // One-hot AND-OR mux of the winning requester's payload.
    always_comb begin
        sel_reg     = '0;
        sel_data    = '0;
        sel_flag_we = 1'b0;
        sel_ovf     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_reg     = sel_reg  | req_reg[i*REG_AW +: REG_AW];
                sel_data    = sel_data | req_data[i*DATA_W +: DATA_W];
                sel_flag_we = sel_flag_we | req_flag_we[i];
                sel_ovf     = sel_ovf | req_ovf[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= PTR_W'(NREQ - 1);
            ovf_q     <= 1'b0;
            gpr_rw    <= 1'b0;
            gpr_wreg  <= '0;
            gpr_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rr_ptr    <= win_idx;
                        // Writes to R0 are consumed but never strobed.
                        gpr_rw    <= (sel_reg != REG_ZERO);
                        gpr_wreg  <= sel_reg;
                        gpr_wdata <= sel_data;
                        if (sel_flag_we) begin
                            ovf_q <= sel_ovf;
                            state <= ST_FLAG;
                        end
                    end else begin
                        gpr_rw <= 1'b0;
                    end
                end
                ST_FLAG: begin
                    // Second write always follows the data write, so a data
                    // write to FLAG_REG is overwritten by the flag value.
                    gpr_rw    <= 1'b1;
                    gpr_wreg  <= FLAG_REG;
                    gpr_wdata <= {{(DATA_W-1){1'b0}}, ovf_q};
                    state     <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    gpr_rw <= 1'b0;
                end
            endcase
        end
    end

endmodule
